// File: rtl/cmm_divide_arbiter.sv
// Round-robin, packet-locked arbiter sharing one scalar-divide datapath among N_REQ streams.
// An ID FIFO records the requester of every issued beat so results return in issue order.
module cmm_divide_arbiter #(
    parameter int unsigned  N_REQ    = 4,
    parameter int unsigned  DATA_W   = 512,
    parameter int unsigned  ID_DEPTH = 4,
    localparam int unsigned ID_W     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ*DATA_W-1:0] req_tdata,
    input  logic [N_REQ-1:0]        req_tvalid,
    input  logic [N_REQ-1:0]        req_tlast,
    input  logic [N_REQ-1:0]        req_tuser,
    output logic [N_REQ-1:0]        req_tready,
    output logic [DATA_W-1:0]       div_s_tdata,
    output logic                    div_s_tvalid,
    output logic                    div_s_tlast,
    output logic                    div_s_tuser,
    input  logic                    div_s_tready,
    input  logic [DATA_W-1:0]       div_m_tdata,
    input  logic                    div_m_tvalid,
    input  logic                    div_m_tlast,
    input  logic                    div_m_tuser,
    output logic                    div_m_tready,
    output logic [DATA_W-1:0]       rsp_tdata,
    output logic                    rsp_tlast,
    output logic                    rsp_tuser,
    output logic [N_REQ-1:0]        rsp_tvalid,
    input  logic [N_REQ-1:0]        rsp_tready,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    err_orphan
);

    localparam int unsigned PTR_W = $clog2(ID_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  fifo_q [ID_DEPTH];
    logic [ID_W-1:0]  fifo_d [ID_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic             fifo_full, fifo_empty;
    logic             issue, pop, any_req;
    logic [ID_W-1:0]  head, pick;
    int unsigned      idx;

    assign fifo_full  = (count_q == CNT_W'(ID_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // First valid requester after the rr pointer, wrapping around.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(rr_q) + i) % N_REQ;
            if (!any_req && req_tvalid[idx]) begin
                any_req = 1'b1;
                pick    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        err_d        = err_q;
        issue        = 1'b0;
        pop          = 1'b0;
        req_tready   = '0;
        div_s_tdata  = '0;
        div_s_tvalid = 1'b0;
        div_s_tlast  = 1'b0;
        div_s_tuser  = 1'b0;
        div_m_tready = 1'b0;
        rsp_tdata    = '0;
        rsp_tlast    = 1'b0;
        rsp_tuser    = 1'b0;
        rsp_tvalid   = '0;

        // Combinational outputs are forced low for as long as reset is held.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_d = pick;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    div_s_tdata          = req_tdata[grant_q*DATA_W +: DATA_W];
                    div_s_tlast          = req_tlast[grant_q];
                    div_s_tuser          = req_tuser[grant_q];
                    div_s_tvalid         = req_tvalid[grant_q] & ~fifo_full;
                    req_tready[grant_q]  = div_s_tready & ~fifo_full;
                    issue                = div_s_tvalid & div_s_tready;
                    if (issue && div_s_tlast) begin
                        rr_d    = grant_q;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            rsp_tdata = div_m_tdata;
            rsp_tlast = div_m_tlast;
            rsp_tuser = div_m_tuser;
            if (fifo_empty) begin
                // Nobody owns this result: drop it and flag the error.
                div_m_tready = 1'b1;
                if (div_m_tvalid) begin
                    err_d = 1'b1;
                end
            end else begin
                rsp_tvalid[head] = div_m_tvalid;
                div_m_tready     = rsp_tready[head];
                pop              = div_m_tvalid & rsp_tready[head];
            end
        end

        if (issue) begin
            fifo_d[wr_ptr_q] = grant_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(issue) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_q     <= ID_W'(N_REQ - 1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < ID_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            fifo_q   <= fifo_d;
        end
    end

    assign busy       = (state_q == StBusy) | ~fifo_empty;
    assign grant_id   = grant_q;
    assign err_orphan = err_q;

endmodule

// File: tb/tb_cmm_divide_arbiter.sv
// Directed bench for cmm_divide_arbiter: a 1-cycle-latency divider stub returns data+1,
// and issue/response handshakes are logged and compared against hand-computed vectors.
module tb_cmm_divide_arbiter;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned DATA_W   = 512;
    localparam int unsigned ID_DEPTH = 4;
    localparam int unsigned ID_W     = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ*DATA_W-1:0] req_tdata;
    logic [N_REQ-1:0]        req_tvalid, req_tlast, req_tuser, req_tready;
    logic [DATA_W-1:0]       div_s_tdata;
    logic                    div_s_tvalid, div_s_tlast, div_s_tuser, div_s_tready;
    logic [DATA_W-1:0]       div_m_tdata;
    logic                    div_m_tvalid, div_m_tlast, div_m_tuser, div_m_tready;
    logic [DATA_W-1:0]       rsp_tdata;
    logic                    rsp_tlast, rsp_tuser;
    logic [N_REQ-1:0]        rsp_tvalid, rsp_tready;
    logic                    busy, err_orphan;
    logic [ID_W-1:0]         grant_id;

    // Divider stub and manual override used for the orphan case.
    logic [DATA_W+1:0] stub_q [$];
    logic [DATA_W-1:0] stub_m_tdata = '0;
    logic              stub_m_tvalid = 1'b0, stub_m_tlast = 1'b0, stub_m_tuser = 1'b0;
    logic              orph_mode, orph_valid;
    logic [DATA_W-1:0] orph_data;

    assign div_m_tvalid = orph_mode ? orph_valid : stub_m_tvalid;
    assign div_m_tdata  = orph_mode ? orph_data : stub_m_tdata;
    assign div_m_tlast  = orph_mode ? 1'b0 : stub_m_tlast;
    assign div_m_tuser  = orph_mode ? 1'b0 : stub_m_tuser;

    logic [17:0]  src_mem [N_REQ][32];
    int           src_len [N_REQ];
    int           acc_cnt [N_REQ];
    int           cyc;
    logic [31:0]  issue_log [$];
    logic [31:0]  rsp_log [$];
    int           issue_cyc [$];
    logic [31:0]  exp_issue [$];
    logic [31:0]  exp_rsp [$];
    int           n_cmp, n_err, t0;

    cmm_divide_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .ID_DEPTH(ID_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_tdata   (req_tdata),
        .req_tvalid  (req_tvalid),
        .req_tlast   (req_tlast),
        .req_tuser   (req_tuser),
        .req_tready  (req_tready),
        .div_s_tdata (div_s_tdata),
        .div_s_tvalid(div_s_tvalid),
        .div_s_tlast (div_s_tlast),
        .div_s_tuser (div_s_tuser),
        .div_s_tready(div_s_tready),
        .div_m_tdata (div_m_tdata),
        .div_m_tvalid(div_m_tvalid),
        .div_m_tlast (div_m_tlast),
        .div_m_tuser (div_m_tuser),
        .div_m_tready(div_m_tready),
        .rsp_tdata   (rsp_tdata),
        .rsp_tlast   (rsp_tlast),
        .rsp_tuser   (rsp_tuser),
        .rsp_tvalid  (rsp_tvalid),
        .rsp_tready  (rsp_tready),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_orphan  (err_orphan)
    );

    always #5 clk = ~clk;

    // Handshake monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_tvalid[k] && req_tready[k]) acc_cnt[k] <= acc_cnt[k] + 1;
        end
        if (div_s_tvalid && div_s_tready) begin
            issue_log.push_back({8'(grant_id), 4'(div_s_tuser), 4'(div_s_tlast),
                                 div_s_tdata[15:0]});
            issue_cyc.push_back(cyc + 1);
        end
        if ((rsp_tvalid & rsp_tready) != '0) begin
            rsp_log.push_back({8'(rsp_tvalid), 4'(rsp_tuser), 4'(rsp_tlast), rsp_tdata[15:0]});
        end
    end

    // One-cycle-latency divider stub: result = operand + 1.
    always @(posedge clk) begin
        if (!orph_mode && stub_m_tvalid && div_m_tready && stub_q.size() > 0) stub_q.delete(0);
        if (div_s_tvalid && div_s_tready)
            stub_q.push_back({div_s_tuser, div_s_tlast, div_s_tdata + DATA_W'(1)});
        if (stub_q.size() > 0) begin
            stub_m_tvalid <= 1'b1;
            {stub_m_tuser, stub_m_tlast, stub_m_tdata} <= stub_q[0];
        end else begin
            stub_m_tvalid <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic check_logs(input string tag);
        check_eq({tag, "_n_issue"}, issue_log.size(), exp_issue.size());
        for (int i = 0; i < exp_issue.size(); i++)
            check_eq($sformatf("%s_issue%0d", tag, i),
                     (i < issue_log.size()) ? issue_log[i] : 32'hdead_dead, exp_issue[i]);
        check_eq({tag, "_n_rsp"}, rsp_log.size(), exp_rsp.size());
        for (int i = 0; i < exp_rsp.size(); i++)
            check_eq($sformatf("%s_rsp%0d", tag, i),
                     (i < rsp_log.size()) ? rsp_log[i] : 32'hdead_dead, exp_rsp[i]);
    endtask

    task automatic load(input int k, input logic user, input logic last, input logic [15:0] d);
        src_mem[k][src_len[k]] = {user, last, d};
        src_len[k]++;
    endtask

    task automatic clear_logs();
        issue_log.delete();
        rsp_log.delete();
        issue_cyc.delete();
    endtask

    // Advance to the next falling edge, present each source's next beat, settle.
    task automatic cycle();
        logic [17:0] e;
        @(negedge clk);
        for (int k = 0; k < N_REQ; k++) begin
            if (acc_cnt[k] < src_len[k]) begin
                e = src_mem[k][acc_cnt[k]];
                req_tvalid[k] = 1'b1;
                req_tuser[k]  = e[17];
                req_tlast[k]  = e[16];
                req_tdata[k*DATA_W +: DATA_W] = DATA_W'({16'(k + 1), e[15:0]});
            end else begin
                req_tvalid[k] = 1'b0;
                req_tuser[k]  = 1'b0;
                req_tlast[k]  = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        #1;
    endtask

    function automatic logic [31:0] zero_vec();
        return {16'(0), |div_s_tdata, |rsp_tdata, div_s_tvalid, div_s_tlast, div_s_tuser,
                div_m_tready, rsp_tlast, rsp_tuser, busy, err_orphan,
                req_tready, rsp_tvalid};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_tdata = '0; req_tvalid = '0; req_tlast = '0; req_tuser = '0;
        div_s_tready = 1'b1; rsp_tready = '1;
        orph_mode = 1'b0; orph_valid = 1'b0; orph_data = '0;
        n_cmp = 0; n_err = 0;
        @(negedge clk);
        #1;
        check_eq("rst_outputs", zero_vec(), 32'h0);
        check_eq("rst_grant", 32'(grant_id), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single requester, 3-beat packet.
        do_reset();
        load(1, 1'b1, 1'b0, 16'h0010);
        load(1, 1'b0, 1'b0, 16'h0020);
        load(1, 1'b1, 1'b1, 16'h0030);
        cycle();
        t0 = cyc;
        check_eq("t1_idle_busy", 32'(busy), 32'h0);
        cycle();
        check_eq("t1_grant", 32'(grant_id), 32'h1);
        check_eq("t1_req_tready", 32'(req_tready), 32'h2);
        check_eq("t1_div_s_tvalid", 32'(div_s_tvalid), 32'h1);
        cycle();
        check_eq("t1_rsp_tvalid", 32'(rsp_tvalid), 32'h2);
        cycle(); cycle();
        check_eq("t1_busy_mid", 32'(busy), 32'h1);
        cycle();
        check_eq("t1_busy_end", 32'(busy), 32'h0);
        check_eq("t1_bubble", (issue_cyc.size() > 0) ? 32'(issue_cyc[0] - t0) : 32'hffff, 32'd2);
        exp_issue = '{32'h0110_0010, 32'h0100_0020, 32'h0111_0030};
        exp_rsp   = '{32'h0210_0011, 32'h0200_0021, 32'h0211_0031};
        check_logs("t1");

        // Round-robin between req0 and req2 with 1-beat packets.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load(0, 1'b0, 1'b1, 16'h00a0 + 16'(i));
            load(2, 1'b0, 1'b1, 16'h00c0 + 16'(i));
        end
        repeat (16) cycle();
        exp_issue = '{32'h0001_00a0, 32'h0201_00c0, 32'h0001_00a1,
                      32'h0201_00c1, 32'h0001_00a2, 32'h0201_00c2};
        exp_rsp   = '{32'h0101_00a1, 32'h0401_00c1, 32'h0101_00a2,
                      32'h0401_00c2, 32'h0101_00a3, 32'h0401_00c3};
        check_logs("t2");

        // Packet lock: req0 arrives while req1 is mid-packet.
        do_reset();
        for (int i = 0; i < 4; i++) load(1, 1'b0, (i == 3), 16'h00b0 + 16'(i));
        cycle(); cycle();
        load(0, 1'b0, 1'b1, 16'h00d0);
        cycle(); cycle();
        check_eq("t3_lock_ready", 32'(req_tready), 32'h2);
        check_eq("t3_lock_grant", 32'(grant_id), 32'h1);
        repeat (6) cycle();
        exp_issue = '{32'h0100_00b0, 32'h0100_00b1, 32'h0100_00b2, 32'h0101_00b3, 32'h0001_00d0};
        exp_rsp   = '{32'h0200_00b1, 32'h0200_00b2, 32'h0200_00b3, 32'h0201_00b4, 32'h0101_00d1};
        check_logs("t3");
        check_eq("t3_bubble",
                 (issue_cyc.size() > 4) ? 32'(issue_cyc[4] - issue_cyc[3]) : 32'hffff, 32'd2);

        // Backpressure: results for req0 stalled, FIFO fills at 4 entries.
        do_reset();
        rsp_tready = 4'b1110;
        for (int i = 0; i < 6; i++) load(0, 1'b0, (i == 5), 16'h00e0 + 16'(i));
        repeat (7) cycle();
        check_eq("t4_full_issued", issue_log.size(), 32'd4);
        check_eq("t4_full_svalid", 32'(div_s_tvalid), 32'h0);
        check_eq("t4_full_ready", 32'(req_tready), 32'h0);
        check_eq("t4_full_rsp_tvalid", 32'(rsp_tvalid), 32'h1);
        check_eq("t4_full_no_rsp", rsp_log.size(), 32'd0);
        rsp_tready = '1;
        repeat (8) cycle();
        exp_issue = '{32'h0000_00e0, 32'h0000_00e1, 32'h0000_00e2,
                      32'h0000_00e3, 32'h0000_00e4, 32'h0001_00e5};
        exp_rsp   = '{32'h0100_00e1, 32'h0100_00e2, 32'h0100_00e3,
                      32'h0100_00e4, 32'h0100_00e5, 32'h0101_00e6};
        check_logs("t4");
        check_eq("t4_busy_end", 32'(busy), 32'h0);

        // Orphan result with the ID FIFO empty.
        do_reset();
        orph_mode  = 1'b1;
        orph_valid = 1'b1;
        orph_data  = DATA_W'(16'h1234);
        #1;
        check_eq("t5_orph_tready", 32'(div_m_tready), 32'h1);
        check_eq("t5_orph_rsp_tvalid", 32'(rsp_tvalid), 32'h0);
        check_eq("t5_orph_pass", 32'(rsp_tdata[15:0]), 32'h1234);
        check_eq("t5_err_before", 32'(err_orphan), 32'h0);
        cycle();
        check_eq("t5_err_set", 32'(err_orphan), 32'h1);
        orph_valid = 1'b0;
        cycle(); cycle();
        check_eq("t5_err_sticky", 32'(err_orphan), 32'h1);
        orph_mode = 1'b0;
        do_reset();
        check_eq("t5_err_cleared", 32'(err_orphan), 32'h0);

        // Reset in the middle of req3's packet.
        do_reset();
        for (int i = 0; i < 4; i++) load(3, 1'b0, (i == 3), 16'h00f0 + 16'(i));
        repeat (4) cycle();
        reset = 1'b1;
        #1;
        check_eq("t6_rst_outputs", zero_vec(), 32'h0);
        check_eq("t6_rst_grant", 32'(grant_id), 32'h0);
        clear_logs();
        load(0, 1'b0, 1'b1, 16'h0050);
        cycle();
        reset = 1'b0;
        repeat (7) cycle();
        exp_issue = '{32'h0001_0050, 32'h0300_00f2, 32'h0301_00f3};
        exp_rsp   = '{32'h0101_0051, 32'h0800_00f3, 32'h0801_00f4};
        check_logs("t6");
        check_eq("t6_stale_orphan", 32'(err_orphan), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
